// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: FSM states, 2-bit counter encodings
// and the saturating counter update.
package bp_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic ctr_e ctr_next(ctr_e c, logic taken);
        if (taken)
            return (c == ST) ? ST : ctr_e'(c + 2'd1);
        return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolution and redirect signals between pipeline and predictor.
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid;
    logic              ex_is_branch;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  mp_count;

    // Pipeline side.
    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, redirect_valid, redirect_pc, flush,
               br_count, mp_count
    );

    // Predictor side.
    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, redirect_valid, redirect_pc, flush,
               br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Direct-mapped predictor table: combinational lookup port, training write port.
module bp_table
    import bp_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_hit,
    output logic [1:0]        rd_ctr,
    output logic [ADDR_W-1:0] rd_target,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_pc,
    input  logic              wr_taken,
    input  logic [ADDR_W-1:0] wr_target
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic              valid  [DEPTH];
    logic [TAG_W-1:0]  tag    [DEPTH];
    logic [ADDR_W-1:0] target [DEPTH];
    ctr_e              ctr    [DEPTH];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;
    logic             unused_bits;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[ADDR_W-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[ADDR_W-1:IDX_W+2];
    // Instruction-aligned PCs: byte offset bits never take part.
    assign unused_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    // Lookup reads current state, so a same-cycle update is not yet visible.
    assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
    assign rd_ctr    = ctr[rd_idx];
    assign rd_target = target[rd_idx];
    assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);

    // Train on hit, allocate on taken miss, leave not-taken misses alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= CTR_RESET;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
                if (wr_taken) target[wr_idx] <= wr_target;
            end else if (wr_taken) begin
                valid[wr_idx]  <= 1'b1;
                tag[wr_idx]    <= wr_tag;
                target[wr_idx] <= wr_target;
                ctr[wr_idx]    <= CTR_ALLOC;
            end
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Branch predictor top: table lookup, mispredict detection, one-cycle
// redirect/flush FSM and saturating debug counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst_n,
    branch_predictor_if.slave bus
);
    state_e            state;
    logic              hit;
    logic [1:0]        ctr;
    logic [ADDR_W-1:0] tgt;
    logic              resolve, mispredict;
    logic              redirect_valid, flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  br_count, mp_count;

    bp_table #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_pc    (bus.if_pc),
        .rd_hit   (hit),
        .rd_ctr   (ctr),
        .rd_target(tgt),
        .wr_en    (resolve),
        .wr_pc    (bus.ex_pc),
        .wr_taken (bus.ex_taken),
        .wr_target(bus.ex_target)
    );

    assign bus.pred_taken  = hit && ctr[1];
    assign bus.pred_target = bus.pred_taken ? tgt : bus.if_pc + ADDR_W'(4);

    // EX during REDIRECT is wrong-path, so it neither trains nor counts.
    assign resolve    = bus.ex_valid && bus.ex_is_branch && (state == IDLE);
    assign mispredict = resolve &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

    // Redirect FSM with registered redirect/flush, high for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: if (mispredict) begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    flush          <= 1'b1;
                    redirect_pc    <= bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_W'(4);
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (resolve && (br_count != '1)) br_count <= br_count + 1'b1;
            if (mispredict && (mp_count != '1)) mp_count <= mp_count + 1'b1;
        end
    end

    assign bus.redirect_valid = redirect_valid;
    assign bus.flush          = flush;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.br_count       = br_count;
    assign bus.mp_count       = mp_count;
endmodule
